// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider initiator (div_ctrl) and its fix-up logic.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP,
    DRAIN
  } div_state_t;

  localparam logic [63:0] DIV_QUOT_ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] I64_MIN           = 64'h8000_0000_0000_0000;
  localparam logic [31:0] I32_MIN           = 32'h8000_0000;

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/response pipe and divider-side signals of div_ctrl; slave = div_ctrl, master = pipe/divider.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic          flush;
  logic          req_valid;
  logic          req_ready;
  div_op_t       req_op;
  logic          req_word;
  logic [63:0]   req_a;
  logic [63:0]   req_b;
  logic          resp_valid;
  logic          resp_ready;
  logic [63:0]   resp_data;
  logic          div_valid;
  logic [63:0]   div_a;
  logic [63:0]   div_b;
  logic          div_done;
  logic [127:0]  div_c;

  modport master (
    output flush, req_valid, req_op, req_word, req_a, req_b, resp_ready, div_done, div_c,
    input  req_ready, resp_valid, resp_data, div_valid, div_a, div_b
  );

  modport slave (
    input  flush, req_valid, req_op, req_word, req_a, req_b, resp_ready, div_done, div_c,
    output req_ready, resp_valid, resp_data, div_valid, div_a, div_b
  );

endinterface

// File: rtl/div_fixup.sv
// Combinational operand preparation (extension, magnitude, special cases) and result sign fix-up.
// Word-op support is compiled in with DIV_WORD_OP_EN.
module div_fixup
  import div_ctrl_pkg::*;
(
  input  div_op_t       i_op,
  input  logic          i_word,
  input  logic [63:0]   i_a,
  input  logic [63:0]   i_b,
  output logic [63:0]   o_div_a,
  output logic [63:0]   o_div_b,
  output logic          o_neg_a,
  output logic          o_neg_b,
  output logic          o_special,
  output logic [63:0]   o_special_data,
  input  div_op_t       i_rsp_op,
  input  logic          i_rsp_word,
  input  logic          i_rsp_neg_a,
  input  logic          i_rsp_neg_b,
  input  logic [127:0]  i_div_c,
  output logic [63:0]   o_result
);

  logic        w_signed;
  logic        w_is_rem;
  logic        w_div0;
  logic        w_ovf;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_min;
  logic [63:0] w_q;
  logic [63:0] w_r;
  logic [63:0] w_res;

`ifndef DIV_WORD_OP_EN
  logic w_unused_word;
  assign w_unused_word = i_word ^ i_rsp_word;
`endif

  always_comb begin
    w_signed = (i_op == DIV) || (i_op == REM);
    w_is_rem = (i_op == REM) || (i_op == REMU);
    w_ext_a  = i_a;
    w_ext_b  = i_b;
    w_min    = I64_MIN;
`ifdef DIV_WORD_OP_EN
    if (i_word) begin
      w_ext_a = w_signed ? sext32(i_a[31:0]) : {32'h0, i_a[31:0]};
      w_ext_b = w_signed ? sext32(i_b[31:0]) : {32'h0, i_b[31:0]};
      w_min   = sext32(I32_MIN);
    end
`endif
    o_neg_a   = w_signed & w_ext_a[63];
    o_neg_b   = w_signed & w_ext_b[63];
    o_div_a   = o_neg_a ? -w_ext_a : w_ext_a;
    o_div_b   = o_neg_b ? -w_ext_b : w_ext_b;
    w_div0    = (w_ext_b == 64'h0);
    w_ovf     = w_signed & (w_ext_b == DIV_QUOT_ALL_ONES) & (w_ext_a == w_min);
    o_special = w_div0 | w_ovf;
    if (w_div0) begin
      o_special_data = w_is_rem ? w_ext_a : DIV_QUOT_ALL_ONES;
    end else begin
      o_special_data = w_is_rem ? 64'h0 : w_ext_a;
    end
`ifdef DIV_WORD_OP_EN
    // REMUW by zero zero-extended the dividend; the word result is still sign-extended.
    if (i_word) o_special_data = sext32(o_special_data[31:0]);
`endif
  end

  always_comb begin
    w_q = i_div_c[63:0];
    w_r = i_div_c[127:64];
    if ((i_rsp_op == REM) || (i_rsp_op == REMU)) begin
      w_res = i_rsp_neg_a ? -w_r : w_r;
    end else begin
      w_res = (i_rsp_neg_a ^ i_rsp_neg_b) ? -w_q : w_q;
    end
    o_result = w_res;
`ifdef DIV_WORD_OP_EN
    if (i_rsp_word) o_result = sext32(w_res[31:0]);
`endif
  end

endmodule

// File: rtl/div_ctrl.sv
// Execute-stage initiator for the multicycle unsigned divider: FSM, operand and result registers.
// Optional W-variant support via DIV_WORD_OP_EN.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  div_ctrl_if.slave   bus
);

  div_state_t  r_state;
  div_op_t     r_op;
  logic        r_word;
  logic        r_neg_a;
  logic        r_neg_b;
  logic        r_div_valid;
  logic [63:0] r_div_a;
  logic [63:0] r_div_b;
  logic        r_resp_valid;
  logic [63:0] r_resp_data;

  logic        w_accept;
  logic        w_word;
  logic [63:0] w_div_a;
  logic [63:0] w_div_b;
  logic        w_neg_a;
  logic        w_neg_b;
  logic        w_special;
  logic [63:0] w_special_data;
  logic [63:0] w_result;

`ifdef DIV_WORD_OP_EN
  assign w_word = bus.req_word;
`else
  assign w_word = 1'b0;
`endif

  assign w_accept       = bus.req_valid & (r_state == IDLE) & ~bus.flush;
  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.div_valid  = r_div_valid;
  assign bus.div_a      = r_div_a;
  assign bus.div_b      = r_div_b;

  div_fixup u_fixup (
    .i_op           (bus.req_op),
    .i_word         (w_word),
    .i_a            (bus.req_a),
    .i_b            (bus.req_b),
    .o_div_a        (w_div_a),
    .o_div_b        (w_div_b),
    .o_neg_a        (w_neg_a),
    .o_neg_b        (w_neg_b),
    .o_special      (w_special),
    .o_special_data (w_special_data),
    .i_rsp_op       (r_op),
    .i_rsp_word     (r_word),
    .i_rsp_neg_a    (r_neg_a),
    .i_rsp_neg_b    (r_neg_b),
    .i_div_c        (bus.div_c),
    .o_result       (w_result)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state      <= IDLE;
      r_op         <= DIV;
      r_word       <= 1'b0;
      r_neg_a      <= 1'b0;
      r_neg_b      <= 1'b0;
      r_div_valid  <= 1'b0;
      r_div_a      <= 64'h0;
      r_div_b      <= 64'h0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 64'h0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= bus.req_op;
            r_word  <= w_word;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
            if (w_special) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_special_data;
              r_state      <= RESP;
            end else begin
              r_div_a     <= w_div_a;
              r_div_b     <= w_div_b;
              r_div_valid <= 1'b1;
              r_state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_div_valid <= 1'b0;
          r_state     <= bus.flush ? DRAIN : WAIT;
        end
        WAIT: begin
          if (bus.flush) begin
            // Divider already finished this cycle: nothing left to drain.
            r_state <= bus.div_done ? IDLE : DRAIN;
          end else if (bus.div_done) begin
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_result;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (bus.flush || bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        DRAIN: begin
          if (bus.div_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl; the bench plays both the pipe and the divider.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  div_ctrl_if bus ();

  div_ctrl u_dut (
    .clk    (clk),
    .resetn (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request; returns at the negedge of the cycle after acceptance.
  task automatic issue_req(input div_op_t op, input logic word, input logic [63:0] a,
                           input logic [63:0] b);
    @(negedge clk);
    bus.req_op    = op;
    bus.req_word  = word;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic finish_resp(input string tag);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, "_rv_off"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_rdy_back"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic run_normal(input string tag, input div_op_t op, input logic word,
                            input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] exp_da, input logic [63:0] exp_db,
                            input logic [63:0] exp_res, input int wait_cyc, input int hold);
    issue_req(op, word, a, b);
    check({tag, "_dv"}, 64'(bus.div_valid), 64'd1);
    check({tag, "_da"}, bus.div_a, exp_da);
    check({tag, "_db"}, bus.div_b, exp_db);
    repeat (wait_cyc) begin
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "_dv_low"}, 64'(bus.div_valid), 64'd0);
    bus.div_done = 1'b1;
    bus.div_c    = {exp_da % exp_db, exp_da / exp_db};
    @(posedge clk);
    @(negedge clk);
    bus.div_done = 1'b0;
    bus.div_c    = '0;
    check({tag, "_rv"}, 64'(bus.resp_valid), 64'd1);
    check({tag, "_data"}, bus.resp_data, exp_res);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold_rv"}, 64'(bus.resp_valid), 64'd1);
      check({tag, "_hold_data"}, bus.resp_data, exp_res);
    end
    finish_resp(tag);
  endtask

  task automatic run_special(input string tag, input div_op_t op, input logic word,
                             input logic [63:0] a, input logic [63:0] b,
                             input logic [63:0] exp_res);
    issue_req(op, word, a, b);
    check({tag, "_rv"}, 64'(bus.resp_valid), 64'd1);
    check({tag, "_dv"}, 64'(bus.div_valid), 64'd0);
    check({tag, "_data"}, bus.resp_data, exp_res);
    finish_resp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = DIV;
    bus.req_word   = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    bus.div_done   = 1'b0;
    bus.div_c      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_div_valid", 64'(bus.div_valid), 64'd0);
    check("rst_div_a", bus.div_a, 64'd0);
    check("rst_div_b", bus.div_b, 64'd0);
    check("rst_resp_data", bus.resp_data, 64'd0);
    rst = 1'b0;

    // Normal path; first one also holds resp_ready low for 3 cycles.
    run_normal("divu", DIVU, 1'b0, 64'd100, 64'd7, 64'd100, 64'd7, 64'd14, 1, 3);
    run_normal("remu", REMU, 1'b0, 64'd100, 64'd7, 64'd100, 64'd7, 64'd2, 2, 0);
    run_normal("div_neg", DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd7, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 1, 0);
    run_normal("rem_neg", REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd7, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 3, 0);
    run_normal("div_negb", DIV, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd20, 64'd3,
               64'hFFFF_FFFF_FFFF_FFFA, 1, 0);
    run_normal("rem_negb", REM, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd20, 64'd3,
               64'd2, 1, 0);

    // Special cases resolved locally.
    run_special("div_by0", DIV, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run_special("rem_by0", REM, 1'b0, 64'd5, 64'd0, 64'd5);
    run_special("div_ovf", DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000);
    run_special("rem_ovf", REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'd0);

`ifdef DIV_WORD_OP_EN
    run_special("divw_ovf", DIV, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_8000_0000);
    run_special("remuw_by0", REMU, 1'b1, 64'h0000_0001_8000_0007, 64'hFFFF_FFFF_0000_0000,
                64'hFFFF_FFFF_8000_0007);
    run_normal("divuw", DIVU, 1'b1, 64'h0000_0001_0000_0064, 64'd7, 64'd100, 64'd7, 64'd14,
               1, 0);
`else
    run_normal("divu_word_ign", DIVU, 1'b1, 64'h0000_0001_0000_0064, 64'd7,
               64'h0000_0001_0000_0064, 64'd7, 64'h0000_0000_2492_4932, 1, 0);
`endif

    // Flush two cycles into WAIT: drain until div_done, no response.
    issue_req(DIVU, 1'b0, 64'd100, 64'd7);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drain_req_ready", 64'(bus.req_ready), 64'd0);
      check("drain_resp_valid", 64'(bus.resp_valid), 64'd0);
      check("drain_div_b", bus.div_b, 64'd7);
      @(posedge clk);
      @(negedge clk);
    end
    bus.div_done = 1'b1;
    bus.div_c    = {64'd2, 64'd14};
    @(posedge clk);
    @(negedge clk);
    bus.div_done = 1'b0;
    bus.div_c    = '0;
    check("drain_done_ready", 64'(bus.req_ready), 64'd1);
    check("drain_done_rv", 64'(bus.resp_valid), 64'd0);
    check("drain_done_div_b", bus.div_b, 64'd7);

    // Flush in RESP drops the result.
    issue_req(DIV, 1'b0, 64'd5, 64'd0);
    check("fresp_rv", 64'(bus.resp_valid), 64'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b0;
    check("fresp_rv_off", 64'(bus.resp_valid), 64'd0);
    check("fresp_ready", 64'(bus.req_ready), 64'd1);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.req_op    = DIV;
    bus.req_a     = 64'd5;
    bus.req_b     = 64'd0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    check("fidle_rv", 64'(bus.resp_valid), 64'd0);
    check("fidle_ready", 64'(bus.req_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Execute-stage initiator for the multicycle unsigned divider. It accepts RV64M divide/remainder requests from the execute pipe and resolves divide-by-zero and signed overflow locally. All other cases go to the divider as unsigned magnitudes over its valid/done interface, and the block applies the sign fix-up before returning a 64-bit result with a valid/ready handshake. It sits between the execute ALU dispatch and the divider and is the only driver of the divider's inputs.

## Interface
- No parameters; widths fixed by RV64.
- clk  in  1  clock, rising edge.
- resetn  in  1  reset; synchronous, active-high (asserted = 1 resets).
- flush  in  1  pipeline flush; kills the in-flight or pending request.
- req_valid  in  1  request present.
- req_ready  out  1  `state == IDLE`; combinational.
- req_op  in  2  div_op_t: DIV=0, DIVU=1, REM=2, REMU=3.
- req_word  in  1  W-variant (32-bit operands, sign-extended result).
- req_a, req_b  in  64  dividend, divisor.
- resp_valid  out  1  result valid; held until resp_ready.
- resp_ready  in  1  consumer accepts.
- resp_data  out  64  result.
- div_valid  out  1  start pulse to divider.
- div_a, div_b  out  64  unsigned dividend and divisor magnitudes.
- div_done  in  1  divider done; ignored outside WAIT/DRAIN.
- div_c  in  128  {remainder, quotient} from divider.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP, DRAIN.
- **Accept:** a request is accepted when `req_valid & req_ready & ~flush`. Operands are latched into op/word/sign registers.
- **Word ops:** signed ops sign-extend `a[31:0]` and `b[31:0]`; unsigned ops zero-extend them.
- **Divide-by-zero** (divisor value after word extension is 0):
  - IDLE→RESP directly.
  - DIV/DIVU return all ones.
  - REM/REMU return the dividend (word ops: sext32 of `a[31:0]`).
- **Signed overflow** (DIV/REM, dividend = min-negative of the operating width, divisor = -1):
  - IDLE→RESP.
  - DIV returns the dividend.
  - REM returns 0.
- **Otherwise:**
  - IDLE→ISSUE. `div_a`/`div_b` are registered |a|/|b| for signed ops and raw values for unsigned ops.
  - ISSUE: `div_valid = 1` for exactly this cycle, then →WAIT.
  - WAIT: `div_a`/`div_b` are held constant, because the divider reads b every iteration. On `div_done = 1` the result is captured and the block goes →RESP.
- **Fix-up:**
  - Quotient is negated when the signs differ (signed ops).
  - Remainder takes the dividend's sign.
  - Word ops: result is sext32 of the low 32 bits.
- **RESP:** `resp_valid = 1`, `resp_data` stable. On `resp_ready` → IDLE.
- **Flush:**
  - IDLE: request not accepted.
  - ISSUE or WAIT: →DRAIN. The divider cannot be aborted, so DRAIN waits for `div_done`, then →IDLE, and no response is produced.
  - RESP: →IDLE, result dropped.
  - DRAIN: no effect.
  - Flush has priority over `resp_ready`, `div_done` and accept.
- **Reset values:**
  - state IDLE, so `req_ready = 1`.
  - `resp_valid`, `div_valid`, `div_a`, `div_b`, `resp_data` all 0.
  - Reset mid-operation abandons everything. The divider shares the reset, so no drain is needed.

## Timing
- Accept at cycle T.
- Normal path:
  - ISSUE at T+1.
  - WAIT from T+2 until the first cycle D with `div_done = 1`.
  - `resp_valid` first high at D+1.
- Special-case path: `resp_valid` at T+1; `div_valid` never asserted.
- Response handshake completes at cycle R (`resp_valid & resp_ready`); `req_ready = 1` at R+1. No accept happens in the same cycle as a response.
- `div_valid` is never high outside ISSUE. `div_a`/`div_b` change only on accept.

## Configuration
- **`DIV_WORD_OP_EN`** defined: W-variants (DIVW/DIVUW/REMW/REMUW) are supported as above.
- **Undefined:**
  - `req_word` is ignored and treated as 0.
  - All word-extension logic is removed.
  - Only 64-bit semantics apply.

## Structure
- **Shared package (pipes):**
  - `div_op_t` enum.
  - `div_state_t` enum.
  - Constants `DIV_QUOT_ALL_ONES` and `I64_MIN` / `I32_MIN`.
- **Sub-module `div_fixup`:** combinational, used for both operand preparation (extension, abs, special-case detection) and result sign correction/word extension. The top holds the FSM and registers.

## Test plan
- DIVU a=100, b=7 → `div_valid` pulse at T+1 with `div_a = 100`, `div_b = 7`; `resp_data = 14` one cycle after `div_done`. REMU same operands → 2.
- DIV a=-7, b=2 → `div_a = 7`; `resp_data = -3` (0xFFFF_FFFF_FFFF_FFFD). REM same operands → -1.
- DIV a=5, b=0 → `resp_valid` at T+1, data all ones, `div_valid` never asserted. REM a=5, b=0 → 5.
- DIV a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000 at T+1. With `DIV_WORD_OP_EN`, DIVW a=0x8000_0000, b=-1 → 0xFFFF_FFFF_8000_0000.
- Flush two cycles into WAIT → no `resp_valid`; `req_ready` stays 0 until the cycle after `div_done`, then 1. `div_b` is stable throughout.
- `resp_ready` held low 3 cycles in RESP → `resp_valid` and `resp_data` held constant; IDLE the cycle after `resp_ready` rises.
